// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: valid/ready request issue, stall hold, trap/branch redirects.
// Build option: define PC_RVC_EN for compressed-instruction support (+2 step, halfword alignment).
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_target,
  input  logic            compressed,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_misalign,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            valid_q, valid_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;

  logic            pend_valid, pend_valid_nxt;
  logic            pend_trap, pend_trap_nxt;
  logic [XLEN-1:0] pend_target, pend_target_nxt;

  logic            mis_q, mis_nxt;
  logic [XLEN-1:0] mis_addr_q, mis_addr_nxt;

  logic            accept;
  logic            waiting;
  logic            br_bad;
  logic            br_ok;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] pc_inc;
  logic            unused_bits;

  assign accept  = valid_q & if_req_ready;
  assign waiting = valid_q & ~if_req_ready;
  assign trap_pc = {trap_target[XLEN-1:2], 2'b00};

`ifdef PC_RVC_EN
  assign br_bad      = branch_target[0];
  assign pc_inc      = compressed ? XLEN'(2) : XLEN'(4);
  assign unused_bits = ^trap_target[1:0];
`else
  assign br_bad      = |branch_target[1:0];
  assign pc_inc      = XLEN'(4);
  assign unused_bits = ^{compressed, trap_target[1:0]};
`endif

  assign br_ok = branch_take & ~br_bad;

  // Sequencing: when a new request may be issued and when the fetch is parked.
  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        valid_nxt = 1'b0;
      end
      RUN: begin
        if (stall && (accept || !valid_q)) begin
          state_nxt = HOLD;
          valid_nxt = 1'b0;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        valid_nxt = 1'b0;
        if (!stall) begin
          state_nxt = RUN;
          valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = BOOT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Next address and redirect capture; pc is frozen while a request waits for ready.
  always_comb begin
    pc_nxt          = pc_q;
    pend_valid_nxt  = pend_valid;
    pend_trap_nxt   = pend_trap;
    pend_target_nxt = pend_target;
    if (accept) begin
      if (trap_take)       pc_nxt = trap_pc;
      else if (br_ok)      pc_nxt = branch_target;
      else if (pend_valid) pc_nxt = pend_target;
      else                 pc_nxt = pc_q + pc_inc;
      pend_valid_nxt = 1'b0;
      pend_trap_nxt  = 1'b0;
    end else if (waiting) begin
      if (trap_take) begin
        pend_valid_nxt  = 1'b1;
        pend_trap_nxt   = 1'b1;
        pend_target_nxt = trap_pc;
      end else if (br_ok && !(pend_valid && pend_trap)) begin
        pend_valid_nxt  = 1'b1;
        pend_trap_nxt   = 1'b0;
        pend_target_nxt = branch_target;
      end
    end else begin
      if (trap_take)  pc_nxt = trap_pc;
      else if (br_ok) pc_nxt = branch_target;
    end
  end

  always_comb begin
    mis_nxt      = branch_take & br_bad & ~trap_take;
    mis_addr_nxt = mis_addr_q;
    if (mis_nxt) mis_addr_nxt = branch_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      valid_q     <= 1'b0;
      pc_q        <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_trap   <= 1'b0;
      pend_target <= '0;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      state       <= state_nxt;
      valid_q     <= valid_nxt;
      pc_q        <= pc_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_trap   <= pend_trap_nxt;
      pend_target <= pend_target_nxt;
      mis_q       <= mis_nxt;
      mis_addr_q  <= mis_addr_nxt;
    end
  end

  assign if_req_valid  = valid_q;
  assign pc_out        = pc_q;
  assign pc_misalign   = mis_q;
  assign misalign_addr = mis_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_take;
  logic [31:0] branch_target;
  logic        trap_take;
  logic [31:0] trap_target;
  logic        compressed;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] pc_out;
  logic        pc_misalign;
  logic [31:0] misalign_addr;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_take(branch_take), .branch_target(branch_target),
    .trap_take(trap_take), .trap_target(trap_target),
    .compressed(compressed),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .pc_out(pc_out), .pc_misalign(pc_misalign), .misalign_addr(misalign_addr)
  );

  // Behavioural model: phase 0 = booting, 1 = issuing, 2 = parked by stall.
  typedef struct {bit is_trap; logic [31:0] addr;} redir_t;
  redir_t      m_pend[$];
  int          m_phase;
  bit          m_valid;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_mis_addr;

  function automatic bit target_bad(logic [31:0] t);
`ifdef PC_RVC_EN
    return t[0];
`else
    return t % 4 != 0;
`endif
  endfunction

  function automatic void model_step();
    bit acc, outst, bad, pend_is_trap;
    logic [31:0] tvec, step;
    redir_t r;
    if (rst) begin
      m_pc = 32'h0; m_valid = 0; m_mis = 0; m_mis_addr = 32'h0;
      m_phase = 0; m_pend.delete();
      return;
    end
    tvec = trap_target - (trap_target % 4);
    bad  = target_bad(branch_target);
`ifdef PC_RVC_EN
    step = compressed ? 32'd2 : 32'd4;
`else
    step = 32'd4;
`endif
    acc   = m_valid && if_req_ready;
    outst = m_valid && !if_req_ready;
    m_mis = branch_take && bad && !trap_take;
    if (m_mis) m_mis_addr = branch_target;
    pend_is_trap = (m_pend.size() > 0) && m_pend[0].is_trap;
    if (acc) begin
      if (trap_take)                 m_pc = tvec;
      else if (branch_take && !bad)  m_pc = branch_target;
      else if (m_pend.size() > 0)    m_pc = m_pend[0].addr;
      else                           m_pc = m_pc + step;
      m_pend.delete();
    end else if (outst) begin
      if (trap_take) begin
        r.is_trap = 1; r.addr = tvec;
        m_pend.delete(); m_pend.push_back(r);
      end else if (branch_take && !bad && !pend_is_trap) begin
        r.is_trap = 0; r.addr = branch_target;
        m_pend.delete(); m_pend.push_back(r);
      end
    end else begin
      if (trap_take)                 m_pc = tvec;
      else if (branch_take && !bad)  m_pc = branch_target;
    end
    case (m_phase)
      0: begin m_phase = 1; m_valid = 0; end
      1: begin
        if (stall && (acc || !m_valid)) begin m_phase = 2; m_valid = 0; end
        else m_valid = 1;
      end
      default: if (!stall) begin m_phase = 1; m_valid = 1; end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("model valid", {31'b0, if_req_valid}, {31'b0, m_valid});
    chk("model pc", pc_out, m_pc);
    chk("model misalign", {31'b0, pc_misalign}, {31'b0, m_mis});
    if (m_mis) chk("model misalign_addr", misalign_addr, m_mis_addr);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    stall = 0; branch_take = 0; branch_target = 0;
    trap_take = 0; trap_target = 0; compressed = 0;
  endtask

  initial begin
    rst = 1; if_req_ready = 1;
    idle_inputs();
    tick(); tick();
    chk("reset pc", pc_out, 32'h0);
    chk("reset valid", {31'b0, if_req_valid}, 32'h0);
    chk("reset misalign", {31'b0, pc_misalign}, 32'h0);
    chk("reset misalign_addr", misalign_addr, 32'h0);

    // Boot: valid at second cycle, then 0,4,8,12.
    rst = 0;
    tick(); chk("boot valid c1", {31'b0, if_req_valid}, 32'h0);
    tick(); chk("boot valid c2", {31'b0, if_req_valid}, 32'h1);
    chk("boot pc0", pc_out, 32'h0);
    tick(); chk("boot pc4", pc_out, 32'h4);
    tick(); chk("boot pc8", pc_out, 32'h8);
    tick(); chk("boot pc12", pc_out, 32'hC);

    // Wrap-around.
    branch_take = 1; branch_target = 32'hFFFF_FFFC;
    tick(); chk("wrap load", pc_out, 32'hFFFF_FFFC);
    idle_inputs();
    tick(); chk("wrap to 0", pc_out, 32'h0);

    // Redirect captured while waiting for ready.
    if_req_ready = 0; branch_take = 1; branch_target = 32'h100;
    tick(); chk("pend hold pc", pc_out, 32'h0);
    chk("pend hold valid", {31'b0, if_req_valid}, 32'h1);
    idle_inputs();
    tick(); chk("pend hold pc2", pc_out, 32'h0);
    if_req_ready = 1;
    tick(); chk("pend applied", pc_out, 32'h100);

    // Trap beats branch; masked trap vector.
    trap_take = 1; trap_target = 32'h203; branch_take = 1; branch_target = 32'h400;
    tick(); chk("trap wins pc", pc_out, 32'h200);
    chk("trap no misalign", {31'b0, pc_misalign}, 32'h0);
    branch_target = 32'h402;
    tick(); chk("trap hides misalign", {31'b0, pc_misalign}, 32'h0);
    chk("trap pc again", pc_out, 32'h200);

    // Misaligned branch.
    idle_inputs(); branch_take = 1; branch_target = 32'h102;
    tick();
`ifdef PC_RVC_EN
    chk("rvc half target", pc_out, 32'h102);
    chk("rvc no misalign", {31'b0, pc_misalign}, 32'h0);
`else
    chk("misalign pulse", {31'b0, pc_misalign}, 32'h1);
    chk("misalign addr", misalign_addr, 32'h102);
    chk("misalign pc seq", pc_out, 32'h204);
`endif
    idle_inputs();
    tick(); chk("misalign one cycle", {31'b0, pc_misalign}, 32'h0);

    // Stall for three cycles, then reset with a pending redirect.
    trap_take = 1; trap_target = 32'h500;
    tick(); chk("trap to 500", pc_out, 32'h500);
    idle_inputs(); stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall valid low", {31'b0, if_req_valid}, 32'h0);
      chk("stall pc frozen", pc_out, 32'h504);
    end
    stall = 0;
    tick(); chk("unstall valid", {31'b0, if_req_valid}, 32'h1);
    chk("unstall pc", pc_out, 32'h504);
    if_req_ready = 0; branch_take = 1; branch_target = 32'h300;
    tick(); idle_inputs();
    rst = 1;
    tick(); chk("mid rst pc", pc_out, 32'h0);
    chk("mid rst valid", {31'b0, if_req_valid}, 32'h0);
    rst = 0; if_req_ready = 1;
    tick(); tick(); chk("post rst pc0", pc_out, 32'h0);
    tick(); chk("pending cleared", pc_out, 32'h4);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      stall         = ($urandom_range(0, 5) == 0);
      if_req_ready  = ($urandom_range(0, 3) != 0);
      branch_take   = ($urandom_range(0, 6) == 0);
      trap_take     = ($urandom_range(0, 14) == 0);
      compressed    = $urandom_range(0, 1) == 1;
      branch_target = $urandom();
      if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) branch_target = 32'hFFFF_FFF8;
      trap_target   = $urandom();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
